// File: rtl/nibble_serial_sub_16_pkg.sv
// Shared types and sizing for the nibble-serial 16-bit subtractor.
package nibble_serial_sub_16_pkg;
  localparam int WIDTH = 16;
  localparam int NIB   = 4;
  localparam int NNIB  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/nibble_serial_sub_16_sub_nibble_4.sv
// Combinational 4-bit subtract with borrow; also exposes the borrow into bit 3
// so the top can derive signed overflow on the most significant nibble.
module sub_nibble_4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_bi,
  output logic [3:0] o_d,
  output logic       o_bo,
  output logic       o_b3
);
  logic [4:0] w_full;
  logic [3:0] w_low;

  assign w_full = {1'b0, i_a} - {1'b0, i_b} - {4'd0, i_bi};
  assign w_low  = {1'b0, i_a[2:0]} - {1'b0, i_b[2:0]} - {3'd0, i_bi};

  assign o_d  = w_full[3:0];
  assign o_bo = w_full[4];
  assign o_b3 = w_low[3];
endmodule

// File: rtl/nibble_serial_sub_16.sv
// 16-bit subtractor D = A - B - bin, evaluated one nibble per cycle through a
// single shared 4-bit subtract cell; results commit only when all nibbles finish.
//
// state   | meaning
// IDLE    | waiting for start; operands captured on the accepting edge
// CALC    | one nibble per cycle, counter 0..3
// DONE    | one-cycle done pulse, then back to IDLE
module nibble_serial_sub_16
  import nibble_serial_sub_16_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_bin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_d,
  output logic             o_bout,
  output logic             o_ovf,
  output logic             o_zero
);
  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_shadow;
  logic [1:0]       r_cnt;
  logic             r_borrow;

  logic [WIDTH-1:0] w_a_sh;
  logic [WIDTH-1:0] w_b_sh;
  logic [NIB-1:0]   w_d;
  logic             w_bo;
  logic             w_b3;
  logic [WIDTH-1:0] w_result;

  assign w_a_sh   = r_a >> {r_cnt, 2'b00};
  assign w_b_sh   = r_b >> {r_cnt, 2'b00};
  assign w_result = {w_d, r_shadow[11:0]};

  sub_nibble_4 u_sub (
    .i_a  (w_a_sh[NIB-1:0]),
    .i_b  (w_b_sh[NIB-1:0]),
    .i_bi (r_borrow),
    .o_d  (w_d),
    .o_bo (w_bo),
    .o_b3 (w_b3)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_shadow <= '0;
      r_cnt    <= 2'd0;
      r_borrow <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_d      <= '0;
      o_bout   <= 1'b0;
      o_ovf    <= 1'b0;
      o_zero   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            r_a      <= i_a;
            r_b      <= i_b;
            r_borrow <= i_bin;
            r_cnt    <= 2'd0;
            o_busy   <= 1'b1;
            r_state  <= ST_CALC;
          end
        end
        ST_CALC: begin
          case (r_cnt)
            2'd0:    r_shadow[3:0]   <= w_d;
            2'd1:    r_shadow[7:4]   <= w_d;
            2'd2:    r_shadow[11:8]  <= w_d;
            default: r_shadow[15:12] <= w_d;
          endcase
          r_borrow <= w_bo;
          r_cnt    <= r_cnt + 2'd1;
          // Last nibble: publish the assembled word straight from the cell output.
          if (r_cnt == 2'(NNIB - 1)) begin
            o_d     <= w_result;
            o_bout  <= w_bo;
            o_ovf   <= w_b3 ^ w_bo;
            o_zero  <= (w_result == '0);
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          o_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          o_busy  <= 1'b0;
          o_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_sub_16.sv
// Scoreboard bench for nibble_serial_sub_16: expected results are queued on
// each accepted start and compared when done pulses.
module tb_nibble_serial_sub_16;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic [15:0] i_a = '0;
  logic [15:0] i_b = '0;
  logic        i_bin = 1'b0;
  logic        o_busy, o_done, o_bout, o_ovf, o_zero;
  logic [15:0] o_d;

  typedef struct {
    logic [15:0] d;
    logic        bout;
    logic        ovf;
    logic        zero;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_done = 0;
  int   n_exp_done = 0;
  int   cyc = 0;

  nibble_serial_sub_16 dut (
    .clk     (clk),
    .rst     (rst),
    .i_start (i_start),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_bin   (i_bin),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_d     (o_d),
    .o_bout  (o_bout),
    .o_ovf   (o_ovf),
    .o_zero  (o_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic push_exp(input logic [15:0] a, input logic [15:0] b, input logic bi,
                          input int acc);
    exp_t e;
    logic [16:0] full;
    full   = {1'b0, a} - {1'b0, b} - {16'd0, bi};
    e.d    = full[15:0];
    e.bout = full[16];
    e.ovf  = (a[15] != b[15]) && (full[15] != a[15]);
    e.zero = (full[15:0] == 16'h0000);
    e.acc  = acc;
    sb.push_back(e);
    n_exp_done++;
  endtask

  always @(negedge clk) begin
    if (!rst && o_done) begin
      exp_t e;
      n_done++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("d", {16'd0, o_d}, {16'd0, e.d});
        chk("bout", {31'd0, o_bout}, {31'd0, e.bout});
        chk("ovf", {31'd0, o_ovf}, {31'd0, e.ovf});
        chk("zero", {31'd0, o_zero}, {31'd0, e.zero});
        chk("done_latency", cyc, e.acc + 4);
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((o_busy || o_done) && n < 50);
    if (n >= 50) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  // Drives start at the current negedge, then follows the operation through DONE.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic bi,
                       input bit inject);
    i_a = a; i_b = b; i_bin = bi; i_start = 1'b1;
    push_exp(a, b, bi, cyc + 1);
    @(negedge clk);
    i_start = 1'b0;
    i_a = $urandom; i_b = $urandom; i_bin = 1'($urandom);
    chk("busy_c0", {31'd0, o_busy}, 32'd1);
    if (inject) begin
      i_start = 1'b1; i_a = 16'hFFFF;
    end
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      i_start = 1'b0;
      chk("busy_cn", {31'd0, o_busy}, 32'd1);
      chk("no_early_done", {31'd0, o_done}, 32'd0);
    end
    @(negedge clk);
    chk("busy_done", {31'd0, o_busy}, 32'd0);
    chk("done_high", {31'd0, o_done}, 32'd1);
    @(negedge clk);
    chk("done_pulse", {31'd0, o_done}, 32'd0);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bi);
    wait_idle();
    issue(a, b, bi, 1'b0);
  endtask

  initial begin
    int n, done_before;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_done", {31'd0, o_done}, 32'd0);
    chk("rst_d", {16'd0, o_d}, 32'd0);
    chk("rst_flags", {29'd0, o_bout, o_ovf, o_zero}, 32'd0);
    rst = 1'b0;

    run_op(16'h1234, 16'h0234, 1'b0);
    run_op(16'h0000, 16'h0001, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b0);
    run_op(16'h7FFF, 16'hFFFF, 1'b0);
    run_op(16'h5555, 16'h5554, 1'b1);
    run_op(16'hFFFF, 16'hFFFF, 1'b1);

    // start pulsed mid-CALC must be ignored
    wait_idle();
    issue(16'h00FF, 16'h0001, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    chk("ignored_start_idle", {31'd0, o_busy}, 32'd0);

    // start held high: second accept six edges after the first
    wait_idle();
    i_a = 16'h0010; i_b = 16'h0001; i_bin = 1'b0; i_start = 1'b1;
    push_exp(16'h0010, 16'h0001, 1'b0, cyc + 1);
    @(negedge clk);
    i_a = 16'h0100;
    repeat (5) @(negedge clk);
    chk("held_idle_gap", {31'd0, o_busy}, 32'd0);
    push_exp(16'h0100, 16'h0001, 1'b0, cyc + 1);
    @(negedge clk);
    i_start = 1'b0;
    chk("held_reaccept", {31'd0, o_busy}, 32'd1);

    // reset during second CALC cycle aborts the operation
    wait_idle();
    i_a = 16'h1111; i_b = 16'h0101; i_bin = 1'b0; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    done_before = n_done;
    chk("abort_busy", {31'd0, o_busy}, 32'd0);
    chk("abort_done", {31'd0, o_done}, 32'd0);
    chk("abort_d", {16'd0, o_d}, 32'd0);
    chk("abort_flags", {29'd0, o_bout, o_ovf, o_zero}, 32'd0);
    rst = 1'b0;
    issue(16'h0003, 16'h0001, 1'b0, 1'b0);
    chk("abort_no_extra_done", n_done, done_before + 1);

    for (int i = 0; i < 8; i++)
      run_op(16'($urandom), 16'($urandom), 1'($urandom));

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 32'd0);
    repeat (8) @(negedge clk);
    chk("done_count", n_done, n_exp_done);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/nibble_serial_sub_16.md
NIBBLE_SERIAL_SUB_16 -- requirements
Module: nibble_serial_sub_16

Interface
REQ-001 The block SHALL use clock clk and reset rst, where rst is synchronous and active-high.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 A  input  16  minuend; sampled on the accepting edge.
REQ-006 B  input  16  subtrahend; sampled on the accepting edge.
REQ-007 bin  input  1  borrow-in; sampled on the accepting edge.
REQ-008 busy  output  1  high while state is CALC.
REQ-009 done  output  1  one-cycle pulse, high while state is DONE.
REQ-010 D  output  16  registered difference A - B - bin, modulo 2^16.
REQ-011 bout  output  1  registered borrow-out from bit 15.
REQ-012 ovf  output  1  registered signed overflow flag.
REQ-013 zero  output  1  registered flag, high when D == 0x0000.

Function
REQ-014 The FSM SHALL have three states:
- IDLE to CALC when start = 1.
- CALC to DONE after four nibble cycles.
- DONE to IDLE unconditionally.
REQ-015 On the accepting edge k (IDLE, start = 1), the block SHALL:
- capture A, B and bin into internal registers;
- clear the nibble counter to 0;
- load the running borrow with bin.
REQ-016 On each CALC edge k+1 to k+4, the block SHALL process nibble i = 0 to 3 (i = counter value):
- compute A[4i+3:4i] - B[4i+3:4i] - borrow;
- write the 4-bit result into a shadow register;
- update the running borrow;
- increment the counter.
REQ-017 At edge k+4, the block SHALL commit D, bout, ovf and zero from the completed shadow register and final borrow, then enter DONE.
REQ-018 done SHALL be high for exactly the one cycle between edges k+4 and k+5.
REQ-019 busy SHALL be high for the four cycles between edges k and k+4.
REQ-020 ovf SHALL equal the borrow into bit 15 XOR bout.
REQ-021 D, bout, ovf and zero SHALL hold their values until the next commit; no intermediate nibble value is visible on D.
REQ-022 start SHALL be ignored in CALC and DONE, and A, B and bin changes after the accepting edge SHALL have no effect on the current operation.
REQ-023 With start held high continuously, a new operation SHALL be accepted at edge k+6, giving one result per 6 cycles.
REQ-024 The counter SHALL be 2 bits wide; its wrap from 3 to 0 coincides with the CALC to DONE transition.

Reset
REQ-025 When rst = 1 at an edge, the block SHALL:
- set the state to IDLE;
- clear the counter, running borrow, shadow register and captured operands;
- clear D to 0x0000 and bout, ovf, zero, busy and done to 0.
REQ-026 rst SHALL take priority over start and over any in-progress CALC or DONE state; an aborted operation produces no done pulse.
REQ-027 The first edge after rst deasserts SHALL accept start normally.

Structure
REQ-028 A shared package SHALL hold:
- the FSM state encoding (IDLE, CALC, DONE);
- the constants WIDTH = 16, NIB = 4 and NNIB = 4.
REQ-029 Per-nibble arithmetic SHALL live in one combinational sub-module, sub_nibble_4, with:
- inputs a[3:0], b[3:0], bi;
- outputs d[3:0], bo, and b3, the borrow into bit 3, which the top uses for ovf on nibble 3.
REQ-030 The top level SHALL instantiate exactly one sub_nibble_4 and select the operand nibble by the counter.

Verification
REQ-031 A = 0x1234, B = 0x0234, bin = 0 -> D = 0x1000, bout = 0, ovf = 0, zero = 0, with done high exactly 4 edges after the accepting edge.
REQ-032 A = 0x0000, B = 0x0001, bin = 0 -> D = 0xFFFF, bout = 1, ovf = 0, zero = 0.
REQ-033 A = 0x8000, B = 0x0001, bin = 0 -> D = 0x7FFF, bout = 0, ovf = 1; A = 0x7FFF, B = 0xFFFF -> D = 0x8000, bout = 1, ovf = 1.
REQ-034 A = 0x5555, B = 0x5554, bin = 1 -> D = 0x0000, zero = 1, bout = 0, ovf = 0.
REQ-035 Start with A = 0x00FF, B = 0x0001, then pulse start with A = 0xFFFF during CALC -> the second start is ignored and D = 0x00FE.
REQ-036 Assert rst during the second CALC cycle -> no done pulse, all outputs 0 on the next cycle; the following start with A = 0x0003, B = 0x0001 -> D = 0x0002.
